// File: rtl/i2c_reg_arbiter.sv
// i2c_reg_arbiter: shared 8-bit register bank with I2C write priority, round-robin
// internal access and a shadow copy that is refreshed only while the I2C bus is idle.
// Ports: clk, startRst (async, active-high); i2c_wr_valid/idx/data write path;
//   i2c_busy transaction window; req/req_we/req_idx/req_wdata internal requesters;
//   gnt one-hot grant, rdata read data; shadow_out frozen bank copy, copy_done pulse;
//   err sticky out-of-range flag.
// Optional feature: define I2C_ARB_ERR_EN to enable err; otherwise err is tied 0.
module i2c_reg_arbiter #(
    parameter int          NUM_REQ  = 4,
    parameter int          NUM_REGS = 16,
    parameter logic [7:0]  RST_VAL  = 8'h00
) (
    input  logic                  clk,
    input  logic                  startRst,
    input  logic                  i2c_wr_valid,
    input  logic [7:0]            i2c_wr_idx,
    input  logic [7:0]            i2c_wr_data,
    input  logic                  i2c_busy,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_we,
    input  logic [8*NUM_REQ-1:0]  req_idx,
    input  logic [8*NUM_REQ-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [7:0]            rdata,
    output logic [8*NUM_REGS-1:0] shadow_out,
    output logic                  copy_done,
    output logic                  err
);
    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, SERVE, COPY} state_t;

    state_t        state, state_nx;
    logic [7:0]    bank   [NUM_REGS];
    logic [7:0]    shadow [NUM_REGS];
    logic [PW-1:0] rr_ptr, sel, pick;
    logic          pick_vld;
    logic [AW-1:0] copy_idx;
    logic          copy_pend, busy_q, rst_done;
    logic          busy_fall, copy_go;
    logic          s_we, s_in, i2c_in, collide;
    logic [7:0]    s_idx, s_wdata;
    logic          grant, copy_wr, copy_last;

    assign busy_fall = busy_q & ~i2c_busy;
    // A falling edge in the same cycle counts, so a fresh refresh beats a waiting request.
    assign copy_go   = (copy_pend | busy_fall) & ~i2c_busy;

    assign s_we    = req_we[sel];
    assign s_idx   = req_idx[8*sel +: 8];
    assign s_wdata = req_wdata[8*sel +: 8];
    assign s_in    = {1'b0, s_idx} < 9'(NUM_REGS);
    assign i2c_in  = {1'b0, i2c_wr_idx} < 9'(NUM_REGS);
    // Same-index write race: the I2C write lands first and the internal write retries.
    assign collide = i2c_wr_valid & s_we & (s_idx == i2c_wr_idx);

    // Round-robin pick: first active request at or after rr_ptr.
    always_comb begin
        int j;
        j        = 0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!pick_vld && req[j[PW-1:0]]) begin
                pick     = j[PW-1:0];
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge startRst) begin
        if (startRst) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (copy_go)       state_nx = COPY;
                else if (pick_vld) state_nx = SERVE;
            end
            SERVE: begin
                if (!collide) state_nx = IDLE;
            end
            COPY: begin
                if (i2c_busy || copy_last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        grant     = (state == SERVE) & ~collide;
        copy_wr   = (state == COPY) & ~i2c_busy;
        copy_last = copy_wr & (copy_idx == AW'(NUM_REGS - 1));
    end

    always_ff @(posedge clk or posedge startRst) begin
        if (startRst) begin
            rr_ptr    <= '0;
            sel       <= '0;
            gnt       <= '0;
            rdata     <= 8'h00;
            copy_idx  <= '0;
            copy_pend <= 1'b0;
            copy_done <= 1'b0;
            busy_q    <= 1'b0;
            rst_done  <= 1'b0;
        end else begin
            busy_q    <= i2c_busy;
            rst_done  <= 1'b1;
            copy_done <= copy_last;
            gnt       <= grant ? (NUM_REQ'(1) << sel) : '0;
            if (state == IDLE && !copy_go && pick_vld) sel <= pick;
            if (state == IDLE && copy_go)
                copy_idx <= '0;
            else if (copy_wr)
                copy_idx <= copy_last ? '0 : copy_idx + AW'(1);
            // First cycle after reset release schedules the initial refresh.
            if (!rst_done || busy_fall) copy_pend <= 1'b1;
            else if (copy_last)         copy_pend <= 1'b0;
            if (grant) begin
                rr_ptr <= (sel == PW'(NUM_REQ - 1)) ? '0 : sel + PW'(1);
                if (!s_we) rdata <= s_in ? bank[s_idx[AW-1:0]] : 8'h00;
            end
        end
    end

    always_ff @(posedge clk or posedge startRst) begin
        if (startRst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                bank[i]   <= RST_VAL;
                shadow[i] <= RST_VAL;
            end
        end else begin
            if (grant && s_we && s_in)
                bank[s_idx[AW-1:0]] <= s_wdata;
            if (i2c_wr_valid && i2c_in)
                bank[i2c_wr_idx[AW-1:0]] <= i2c_wr_data;
            if (copy_wr)
                shadow[copy_idx] <= bank[copy_idx];
        end
    end

    always_comb begin
        shadow_out = '0;
        for (int i = 0; i < NUM_REGS; i++)
            shadow_out[8*i +: 8] = shadow[i];
    end

`ifdef I2C_ARB_ERR_EN
    always_ff @(posedge clk or posedge startRst) begin
        if (startRst)
            err <= 1'b0;
        else if ((i2c_wr_valid && !i2c_in) || (grant && !s_in))
            err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_reg_arbiter.sv
// tb_i2c_reg_arbiter: randomized self-checking bench for i2c_reg_arbiter.
// Drives the I2C write path, busy window and four requesters; checks against a bank/shadow model.
module tb_i2c_reg_arbiter;
    logic         clk = 1'b0;
    logic         startRst;
    logic         i2c_wr_valid;
    logic [7:0]   i2c_wr_idx;
    logic [7:0]   i2c_wr_data;
    logic         i2c_busy;
    logic [3:0]   req;
    logic [3:0]   req_we;
    logic [31:0]  req_idx;
    logic [31:0]  req_wdata;
    logic [3:0]   gnt;
    logic [7:0]   rdata;
    logic [127:0] shadow_out;
    logic         copy_done;
    logic         err;

`ifdef I2C_ARB_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_bank   [16];
    logic [7:0] exp_shadow [16];
    int         exp_rr;

    i2c_reg_arbiter #(.NUM_REQ(4), .NUM_REGS(16), .RST_VAL(8'h00)) dut (
        .clk(clk), .startRst(startRst),
        .i2c_wr_valid(i2c_wr_valid), .i2c_wr_idx(i2c_wr_idx),
        .i2c_wr_data(i2c_wr_data), .i2c_busy(i2c_busy),
        .req(req), .req_we(req_we), .req_idx(req_idx), .req_wdata(req_wdata),
        .gnt(gnt), .rdata(rdata), .shadow_out(shadow_out),
        .copy_done(copy_done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] shadow_exp();
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < 16; i++) v[8*i +: 8] = exp_shadow[i];
        return v;
    endfunction

    // Issue one request and wait (bounded) for any grant.
    task automatic do_req(input int k, input logic w, input logic [7:0] ix,
                          input logic [7:0] d, output int lat,
                          output logic [3:0] g, output logic [7:0] rd);
        req = '0;
        req[k] = 1'b1;
        req_we[k] = w;
        req_idx[8*k +: 8] = ix;
        req_wdata[8*k +: 8] = d;
        lat = 0; g = '0; rd = 8'h00;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (gnt !== 4'b0000) begin
                lat = t; g = gnt; rd = rdata;
                break;
            end
        end
        req = '0;
    endtask

    // Wait (bounded) for copy_done; returns ticks taken, 0 on timeout.
    task automatic wait_copy(output int cd);
        cd = 0;
        for (int t = 1; t <= 60; t++) begin
            tick();
            if (copy_done === 1'b1) begin
                cd = t;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int cd;
        startRst = 1'b1;
        tick(); tick();
        checks++;
        if (gnt !== 4'b0 || rdata !== 8'h00 || copy_done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%b rdata=%h copy_done=%b err=%b, need 0", gnt, rdata, copy_done, err);
        end
        checks++;
        if (shadow_out !== 128'h0) begin
            errors++;
            $display("FAIL reset_shadow: got %h need 0", shadow_out);
        end
        startRst = 1'b0;
        wait_copy(cd);
        checks++;
        if (cd == 0) begin
            errors++;
            $display("FAIL reset_initial_copy: copy_done not seen, need a pulse after release");
        end
        checks++;
        if (shadow_out !== shadow_exp()) begin
            errors++;
            $display("FAIL reset_copy_shadow: got %h need %h", shadow_out, shadow_exp());
        end
    endtask

    task automatic test_write();
        int lat; logic [3:0] g; logic [7:0] rd;
        do_req(0, 1'b1, 8'd3, 8'hA5, lat, g, rd);
        checks++;
        if (lat != 2 || g !== 4'b0001) begin
            errors++;
            $display("FAIL write_grant: lat=%0d gnt=%b need lat=2 gnt=0001", lat, g);
        end
        exp_bank[3] = 8'hA5;
        exp_rr = 1;
        checks++;
        if (shadow_out[31:24] !== exp_shadow[3]) begin
            errors++;
            $display("FAIL write_shadow_frozen: got %h need %h", shadow_out[31:24], exp_shadow[3]);
        end
        do_req(2, 1'b0, 8'd3, 8'h00, lat, g, rd);
        checks++;
        if (lat != 2 || g !== 4'b0100 || rd !== 8'hA5) begin
            errors++;
            $display("FAIL write_readback: lat=%0d gnt=%b rdata=%h need 2 0100 a5", lat, g, rd);
        end
        exp_rr = 3;
    endtask

    // Busy falls while requester 0 waits: the refresh runs first, then the grant.
    task automatic test_busy_cycle();
        int cd_t; int g_t; int cd_cnt; logic [3:0] g; logic [7:0] rd;
        i2c_busy = 1'b1;
        tick(); tick();
        checks++;
        if (shadow_out !== shadow_exp()) begin
            errors++;
            $display("FAIL busy_shadow_hold: got %h need %h", shadow_out, shadow_exp());
        end
        i2c_busy = 1'b0;
        req = 4'b0001; req_we[0] = 1'b0; req_idx[7:0] = 8'd3;
        cd_t = 0; g_t = 0; cd_cnt = 0; g = '0; rd = 8'h00;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (copy_done === 1'b1) begin
                cd_cnt++;
                if (cd_t == 0) cd_t = t;
            end
            if (gnt !== 4'b0000) begin
                g_t = t; g = gnt; rd = rdata;
                break;
            end
        end
        req = '0;
        // One cycle to enter COPY, then one entry per cycle.
        checks++;
        if (cd_t != 17 || cd_cnt != 1) begin
            errors++;
            $display("FAIL busy_copy_done: at tick %0d (%0d pulses), need tick 17 (1 pulse)", cd_t, cd_cnt);
        end
        checks++;
        if (g_t != 19 || g !== 4'b0001 || rd !== exp_bank[3]) begin
            errors++;
            $display("FAIL busy_stalled_grant: tick=%0d gnt=%b rdata=%h need 19 0001 %h", g_t, g, rd, exp_bank[3]);
        end
        exp_rr = 1;
        for (int i = 0; i < 16; i++) exp_shadow[i] = exp_bank[i];
        checks++;
        if (shadow_out !== shadow_exp() || shadow_out[31:24] !== 8'hA5) begin
            errors++;
            $display("FAIL busy_shadow_refresh: got %h need %h", shadow_out, shadow_exp());
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] ix [4];
        logic [3:0] eg; int k;
        for (int j = 0; j < 4; j++) begin
            ix[j] = 8'($urandom_range(0, 15));
            req_idx[8*j +: 8] = ix[j];
        end
        req_we = 4'b0000;
        req = 4'b1111;
        for (int t = 1; t <= 10; t++) begin
            tick();
            k = (exp_rr + t/2 - 1) % 4;
            eg = (t % 2 == 0) ? 4'(1 << k) : 4'b0000;
            checks++;
            if (gnt !== eg) begin
                errors++;
                $display("FAIL rr_order: tick %0d gnt=%b need %b", t, gnt, eg);
            end
            if (t % 2 == 0) begin
                checks++;
                if (rdata !== exp_bank[ix[k]]) begin
                    errors++;
                    $display("FAIL rr_rdata: tick %0d got %h need %h", t, rdata, exp_bank[ix[k]]);
                end
            end
        end
        req = '0;
        exp_rr = (exp_rr + 5) % 4;
    endtask

    task automatic test_random();
        logic [3:0] pend; logic [3:0] we;
        logic [7:0] ix [4]; logic [7:0] wd [4];
        int k;
        for (int it = 0; it < 10; it++) begin
            pend = 4'($urandom_range(1, 15));
            for (int j = 0; j < 4; j++) begin
                we[j] = 1'($urandom);
                ix[j] = 8'($urandom_range(0, 15));
                wd[j] = 8'($urandom);
                req_idx[8*j +: 8] = ix[j];
                req_wdata[8*j +: 8] = wd[j];
            end
            req_we = we;
            req = pend;
            while (pend != 4'b0000) begin
                k = -1;
                for (int s = 0; s < 4; s++)
                    if (k < 0 && pend[(exp_rr + s) % 4]) k = (exp_rr + s) % 4;
                tick();
                checks++;
                if (gnt !== 4'b0000) begin
                    errors++;
                    $display("FAIL rand_serve_gap: gnt=%b need 0000", gnt);
                end
                tick();
                checks++;
                if (gnt !== 4'(1 << k)) begin
                    errors++;
                    $display("FAIL rand_grant: gnt=%b need %b", gnt, 4'(1 << k));
                end
                if (!we[k]) begin
                    checks++;
                    if (rdata !== exp_bank[ix[k]]) begin
                        errors++;
                        $display("FAIL rand_rdata: req %0d idx %0d got %h need %h", k, ix[k], rdata, exp_bank[ix[k]]);
                    end
                end else begin
                    exp_bank[ix[k]] = wd[k];
                end
                exp_rr = (k + 1) % 4;
                pend[k] = 1'b0;
                req = pend;
            end
        end
    endtask

    task automatic test_collision();
        int lat; logic [3:0] g; logic [7:0] rd; logic [7:0] old4;
        req = 4'b0010; req_we[1] = 1'b1; req_idx[15:8] = 8'd7; req_wdata[15:8] = 8'h11;
        tick();
        i2c_wr_valid = 1'b1; i2c_wr_idx = 8'd7; i2c_wr_data = 8'h22;
        tick();
        i2c_wr_valid = 1'b0;
        checks++;
        if (gnt !== 4'b0000) begin
            errors++;
            $display("FAIL coll_withheld: gnt=%b need 0000", gnt);
        end
        tick();
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL coll_retry_grant: gnt=%b need 0010", gnt);
        end
        req = '0;
        exp_bank[7] = 8'h11;
        exp_rr = 2;
        do_req(3, 1'b0, 8'd7, 8'h00, lat, g, rd);
        checks++;
        if (lat != 2 || g !== 4'b1000 || rd !== 8'h11) begin
            errors++;
            $display("FAIL coll_final_value: lat=%0d gnt=%b rdata=%h need 2 1000 11", lat, g, rd);
        end
        exp_rr = 0;
        // Read racing an I2C write to the same index sees the old value.
        old4 = exp_bank[4];
        req = 4'b0001; req_we[0] = 1'b0; req_idx[7:0] = 8'd4;
        tick();
        i2c_wr_valid = 1'b1; i2c_wr_idx = 8'd4; i2c_wr_data = 8'h77;
        tick();
        i2c_wr_valid = 1'b0;
        req = '0;
        checks++;
        if (gnt !== 4'b0001 || rdata !== old4) begin
            errors++;
            $display("FAIL coll_read_race: gnt=%b rdata=%h need 0001 %h", gnt, rdata, old4);
        end
        exp_bank[4] = 8'h77;
        exp_rr = 1;
        // Different indices: no stall.
        req = 4'b0010; req_we[1] = 1'b1; req_idx[15:8] = 8'd9; req_wdata[15:8] = 8'h5A;
        tick();
        i2c_wr_valid = 1'b1; i2c_wr_idx = 8'd10; i2c_wr_data = 8'hC3;
        tick();
        i2c_wr_valid = 1'b0;
        req = '0;
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL coll_no_conflict: gnt=%b need 0010", gnt);
        end
        exp_bank[9] = 8'h5A;
        exp_bank[10] = 8'hC3;
        exp_rr = 2;
    endtask

    task automatic test_abort();
        int cd; logic [7:0] nv; logic [7:0] snap [16];
        i2c_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            i2c_wr_valid = 1'b1;
            i2c_wr_idx = 8'(i);
            i2c_wr_data = 8'($urandom);
            exp_bank[i] = i2c_wr_data;
            tick();
        end
        i2c_wr_valid = 1'b0;
        tick();
        checks++;
        if (shadow_out !== shadow_exp()) begin
            errors++;
            $display("FAIL abort_busy_freeze: got %h need %h", shadow_out, shadow_exp());
        end
        i2c_busy = 1'b0;
        cd = 0;
        for (int t = 1; t <= 6; t++) begin
            tick();
            if (copy_done === 1'b1) cd++;
        end
        // Entries 0..4 copied, copy index now 5: bus turns busy again.
        i2c_busy = 1'b1;
        for (int i = 0; i < 5; i++) exp_shadow[i] = exp_bank[i];
        i2c_wr_valid = 1'b1; i2c_wr_idx = 8'd2; i2c_wr_data = 8'h9D;
        tick();
        i2c_wr_valid = 1'b0;
        exp_bank[2] = 8'h9D;
        for (int t = 0; t < 4; t++) begin
            tick();
            if (copy_done === 1'b1) cd++;
        end
        checks++;
        if (cd != 0 || shadow_out !== shadow_exp()) begin
            errors++;
            $display("FAIL abort_partial: pulses=%0d shadow=%h need 0 %h", cd, shadow_out, shadow_exp());
        end
        i2c_busy = 1'b0;
        for (int i = 0; i < 16; i++) snap[i] = exp_bank[i];
        nv = exp_bank[1] ^ 8'hFF;
        cd = 0;
        for (int t = 1; t <= 40; t++) begin
            tick();
            i2c_wr_valid = (t == 4);
            i2c_wr_idx = 8'd1;
            i2c_wr_data = nv;
            if (copy_done === 1'b1) begin
                cd = t;
                break;
            end
        end
        i2c_wr_valid = 1'b0;
        exp_bank[1] = nv;
        for (int i = 0; i < 16; i++) exp_shadow[i] = snap[i];
        checks++;
        if (cd != 17 || shadow_out !== shadow_exp()) begin
            errors++;
            $display("FAIL abort_restart: tick=%0d shadow=%h need 17 %h", cd, shadow_out, shadow_exp());
        end
        i2c_busy = 1'b1;
        tick();
        i2c_busy = 1'b0;
        wait_copy(cd);
        for (int i = 0; i < 16; i++) exp_shadow[i] = exp_bank[i];
        checks++;
        if (cd == 0 || shadow_out[15:8] !== nv || shadow_out !== shadow_exp()) begin
            errors++;
            $display("FAIL abort_next_refresh: tick=%0d shadow=%h need %h", cd, shadow_out, shadow_exp());
        end
    endtask

    task automatic test_range();
        int lat; int cd; logic [3:0] g; logic [7:0] rd;
        i2c_wr_valid = 1'b1; i2c_wr_idx = 8'h20; i2c_wr_data = 8'h5C;
        tick();
        i2c_wr_valid = 1'b0;
        tick();
        checks++;
        if (err !== EXP_ERR) begin
            errors++;
            $display("FAIL range_i2c_err: err=%b need %b", err, EXP_ERR);
        end
        do_req(exp_rr, 1'b1, 8'h10, 8'hEE, lat, g, rd);
        checks++;
        if (lat != 2 || g !== 4'(1 << exp_rr)) begin
            errors++;
            $display("FAIL range_int_write_grant: lat=%0d gnt=%b need 2 %b", lat, g, 4'(1 << exp_rr));
        end
        exp_rr = (exp_rr + 1) % 4;
        i2c_wr_valid = 1'b1; i2c_wr_idx = 8'd3; i2c_wr_data = 8'h3C;
        tick();
        i2c_wr_valid = 1'b0;
        exp_bank[3] = 8'h3C;
        do_req(exp_rr, 1'b0, 8'd3, 8'h00, lat, g, rd);
        exp_rr = (exp_rr + 1) % 4;
        checks++;
        if (rd !== 8'h3C) begin
            errors++;
            $display("FAIL range_prior_read: rdata=%h need 3c", rd);
        end
        do_req(exp_rr, 1'b0, 8'hFF, 8'h00, lat, g, rd);
        exp_rr = (exp_rr + 1) % 4;
        checks++;
        if (lat != 2 || rd !== 8'h00) begin
            errors++;
            $display("FAIL range_int_read: lat=%0d rdata=%h need 2 00", lat, rd);
        end
        i2c_busy = 1'b1;
        tick();
        i2c_busy = 1'b0;
        wait_copy(cd);
        for (int i = 0; i < 16; i++) exp_shadow[i] = exp_bank[i];
        checks++;
        if (cd == 0 || shadow_out !== shadow_exp() || err !== EXP_ERR) begin
            errors++;
            $display("FAIL range_bank_intact: shadow=%h err=%b need %h %b", shadow_out, err, shadow_exp(), EXP_ERR);
        end
        req = 4'b0010; req_we[1] = 1'b0; req_idx[15:8] = 8'd3;
        tick();
        startRst = 1'b1;
        #1;
        req = '0;
        checks++;
        if (gnt !== 4'b0 || err !== 1'b0 || rdata !== 8'h00 || shadow_out !== 128'h0) begin
            errors++;
            $display("FAIL range_mid_reset: gnt=%b err=%b rdata=%h shadow=%h need all 0", gnt, err, rdata, shadow_out);
        end
        tick();
        startRst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_bank[i] = 8'h00;
            exp_shadow[i] = 8'h00;
        end
        exp_rr = 0;
        wait_copy(cd);
        checks++;
        if (cd == 0 || shadow_out !== 128'h0 || gnt !== 4'b0) begin
            errors++;
            $display("FAIL range_post_reset: copy tick=%0d shadow=%h gnt=%b need copy, 0, 0", cd, shadow_out, gnt);
        end
    endtask

    initial begin
        startRst = 1'b1;
        i2c_wr_valid = 1'b0; i2c_wr_idx = 8'h00; i2c_wr_data = 8'h00;
        i2c_busy = 1'b0;
        req = '0; req_we = '0; req_idx = '0; req_wdata = '0;
        for (int i = 0; i < 16; i++) begin
            exp_bank[i] = 8'h00;
            exp_shadow[i] = 8'h00;
        end
        exp_rr = 0;
        test_reset();
        test_write();
        test_busy_cycle();
        test_round_robin();
        test_random();
        test_collision();
        test_abort();
        test_range();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
